sprite_pixel_reader: RTL

//  Read side of the sprite image memory: accepts a fetch request (base word address, word count),

---
 rtl/sprite_pixel_reader_if.sv | 39 +++
 rtl/sprite_pixel_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_reader_if.sv
// Request and pixel-stream handshake bundle for sprite_pixel_reader.
// SPRITE_MIRROR_EN adds the req_mirror request field.
interface sprite_pixel_reader_if #(
  parameter int WORD_W = 24,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_base;
  logic [LEN_W-1:0]  req_len;
`ifdef SPRITE_MIRROR_EN
  logic              req_mirror;
`endif
  logic              pix_valid;
  logic              pix_ready;
  logic [WORD_W-1:0] pix_data;
  logic              pix_last;

`ifdef SPRITE_MIRROR_EN
  modport master (
    output req_valid, req_base, req_len, req_mirror, pix_ready,
    input  req_ready, pix_valid, pix_data, pix_last
  );
  modport slave (
    input  req_valid, req_base, req_len, req_mirror, pix_ready,
    output req_ready, pix_valid, pix_data, pix_last
  );
`else
  modport master (
    output req_valid, req_base, req_len, pix_ready,
    input  req_ready, pix_valid, pix_data, pix_last
  );
  modport slave (
    input  req_valid, req_base, req_len, pix_ready,
    output req_ready, pix_valid, pix_data, pix_last
  );
`endif
endinterface

// File: rtl/sprite_pixel_reader.sv
// Sprite image read engine: sequential RAM reads into a 2-entry buffer feeding a valid/ready pixel stream.
// Optional SPRITE_MIRROR_EN: req_mirror selects descending (horizontally flipped) read order.
module sprite_pixel_reader #(
  parameter int WORD_W = 24,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  sprite_pixel_reader_if.slave bus,
  output logic [ADDR_W-1:0]   mem_a,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              state_r;
  logic                req_ready_r;
  logic                busy_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [LEN_W-1:0]    issue_cnt_r;
  logic [LEN_W-1:0]    out_cnt_r;
  logic                descend_r;

  logic                inflight_r;
  logic                inflight_last_r;
  logic                head_valid_r;
  logic [WORD_W-1:0]   head_data_r;
  logic                head_last_r;
  logic                tail_valid_r;
  logic [WORD_W-1:0]   tail_data_r;
  logic                tail_last_r;

  logic                accept_s;
  logic                pop_s;
  logic                room_s;
  logic                issue_s;
  logic [1:0]          occ_s;
  logic [ADDR_W-1:0]   start_s;
  logic                desc_s;
  logic [ADDR_W-1:0]   next_addr_s;

  // Handshake decode, read-issue permission and start address selection.
  always_comb begin
    accept_s = bus.req_valid && req_ready_r;
    pop_s    = head_valid_r && bus.pix_ready;
    occ_s    = {1'b0, head_valid_r} + {1'b0, tail_valid_r} + {1'b0, inflight_r};
    // A word leaving this cycle frees its slot in time for a read issued now.
    room_s   = (occ_s < 2'd2) || pop_s;
    if ((state_r == ST_FETCH) && (issue_cnt_r != {LEN_W{1'b0}}) && room_s) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
`ifdef SPRITE_MIRROR_EN
    if (bus.req_mirror) begin
      start_s = bus.req_base + ADDR_W'(bus.req_len) - ADDR_ONE;
      desc_s  = 1'b1;
    end else begin
      start_s = bus.req_base;
      desc_s  = 1'b0;
    end
`else
    start_s = bus.req_base;
    desc_s  = 1'b0;
`endif
    if (descend_r) begin
      next_addr_s = addr_r - ADDR_ONE;
    end else begin
      next_addr_s = addr_r + ADDR_ONE;
    end
  end

  // Request FSM with address/issue/output counters and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      issue_cnt_r <= {LEN_W{1'b0}};
      out_cnt_r   <= {LEN_W{1'b0}};
      descend_r   <= 1'b0;
    end else begin
      if (pop_s) begin
        out_cnt_r <= out_cnt_r - LEN_ONE;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r      <= start_s;
            issue_cnt_r <= bus.req_len;
            out_cnt_r   <= bus.req_len;
            descend_r   <= desc_s;
            // Zero-length requests are consumed without leaving IDLE.
            if (bus.req_len != {LEN_W{1'b0}}) begin
              state_r     <= ST_FETCH;
              req_ready_r <= 1'b0;
              busy_r      <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (issue_s) begin
            addr_r      <= next_addr_s;
            issue_cnt_r <= issue_cnt_r - LEN_ONE;
            if (issue_cnt_r == LEN_ONE) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop_s && (out_cnt_r == LEN_ONE)) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // In-flight read tracking and the 2-entry head/tail output buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      head_valid_r    <= 1'b0;
      head_data_r     <= {WORD_W{1'b0}};
      head_last_r     <= 1'b0;
      tail_valid_r    <= 1'b0;
      tail_data_r     <= {WORD_W{1'b0}};
      tail_last_r     <= 1'b0;
    end else begin
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s && (issue_cnt_r == LEN_ONE);
      if (!head_valid_r || pop_s) begin
        if (tail_valid_r) begin
          head_valid_r <= 1'b1;
          head_data_r  <= tail_data_r;
          head_last_r  <= tail_last_r;
          tail_valid_r <= inflight_r;
          if (inflight_r) begin
            tail_data_r <= mem_rdata;
            tail_last_r <= inflight_last_r;
          end
        end else begin
          head_valid_r <= inflight_r;
          head_last_r  <= inflight_r && inflight_last_r;
          if (inflight_r) begin
            head_data_r <= mem_rdata;
          end
        end
      end else if (inflight_r) begin
        // Head is stalled; the returning word parks in the tail slot.
        tail_valid_r <= 1'b1;
        tail_data_r  <= mem_rdata;
        tail_last_r  <= inflight_last_r;
      end
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.pix_valid = head_valid_r;
  assign bus.pix_data  = head_data_r;
  assign bus.pix_last  = head_last_r;
  assign mem_a         = addr_r;
  assign busy          = busy_r;

endmodule
